// File: rtl/md_sched_pkg.sv
// rtl/md_sched_pkg.sv - shared state encoding and constants for the reference-particle scheduler
package md_sched_pkg;

    localparam int DEFAULT_PARTICLE_ID_WIDTH = 7;
    localparam int NUM_SLOT_ADDR             = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ_NUM,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } sched_state_e;

endpackage

// File: rtl/sched_delay_line.sv
// rtl/sched_delay_line.sv - holdable shift register aligning read tags with memory return data
module sched_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d = stage_q;
        if (!hold) begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/ref_particle_scheduler.sv
// rtl/ref_particle_scheduler.sv - sequences one home cell's reference-particle sweep
module ref_particle_scheduler
    import md_sched_pkg::*;
#(
    parameter int PARTICLE_ID_WIDTH = DEFAULT_PARTICLE_ID_WIDTH,
    parameter int RD_LATENCY        = 1,
    parameter int DRAIN_CYCLES      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stall,
    input  logic                         pipe_busy,
    input  logic [PARTICLE_ID_WIDTH-1:0] rd_num,
    output logic                         rd_en,
    output logic [PARTICLE_ID_WIDTH-1:0] rd_addr,
    output logic                         reading_particle_num,
    output logic [PARTICLE_ID_WIDTH-1:0] particle_id,
    output logic [PARTICLE_ID_WIDTH-1:0] ref_id,
    output logic                         phase,
    output logic                         prev_phase,
    output logic                         busy,
    output logic                         done
);

    localparam int W     = PARTICLE_ID_WIDTH;
    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [W-1:0]     NUM_ADDR = W'(NUM_SLOT_ADDR);

    sched_state_e     state_q, state_d;
    logic [W-1:0]     addr_q, addr_d;
    logic [W-1:0]     num_q, num_d;
    logic [W-1:0]     ref_q, ref_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             issued_q, issued_d;
    logic             prev_phase_q;
    logic             rd_en_c;
    logic             dl_hold;
    logic [W:0]       dl_din, dl_dout;
    logic             ret_is_num;
    logic [W-1:0]     ret_id;

    // The tag line freezes with the memory output so a stalled particle stays presented.
    assign dl_hold = stall && (state_q == ST_STREAM);
    assign dl_din  = {rd_en_c && (addr_q == NUM_ADDR), rd_en_c ? addr_q : {W{1'b0}}};

    sched_delay_line #(
        .WIDTH (W + 1),
        .DEPTH (RD_LATENCY)
    ) u_delay_line (
        .clk   (clk),
        .rst_n (rst),
        .hold  (dl_hold),
        .din   (dl_din),
        .dout  (dl_dout)
    );

    assign {ret_is_num, ret_id} = dl_dout;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        num_d    = num_q;
        ref_d    = ref_q;
        cnt_d    = cnt_q;
        issued_d = issued_q;
        rd_en_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_READ_NUM;
                    addr_d   = NUM_ADDR;
                    ref_d    = '0;
                    issued_d = 1'b0;
                end
            end
            ST_READ_NUM: begin
                rd_en_c  = !issued_q;
                issued_d = 1'b1;
                if (ret_is_num) begin
                    num_d = rd_num;
                    if (rd_num == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_STREAM;
                        ref_d    = W'(1);
                        addr_d   = W'(1);
                        issued_d = 1'b0;
                    end
                end
            end
            ST_STREAM: begin
                if (!stall) begin
                    if (!issued_q) begin
                        rd_en_c = 1'b1;
                        if (addr_q == num_q) begin
                            issued_d = 1'b1;
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end else if (ret_id == num_q) begin
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if ((cnt_q == CNT_LAST) && !pipe_busy) begin
                    if (ref_q == num_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_STREAM;
                        ref_d    = ref_q + 1'b1;
                        addr_d   = W'(1);
                        issued_d = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            num_q        <= '0;
            ref_q        <= '0;
            cnt_q        <= '0;
            issued_q     <= 1'b0;
            prev_phase_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            num_q        <= num_d;
            ref_q        <= ref_d;
            cnt_q        <= cnt_d;
            issued_q     <= issued_d;
            prev_phase_q <= phase;
        end
    end

    assign rd_en                = rd_en_c;
    assign rd_addr              = addr_q;
    assign reading_particle_num = ret_is_num;
    assign particle_id          = ret_id;
    assign ref_id               = ref_q;
    assign phase                = (state_q == ST_DRAIN);
    assign prev_phase           = prev_phase_q;
    assign busy                 = (state_q == ST_READ_NUM) || (state_q == ST_STREAM) || (state_q == ST_DRAIN);
    assign done                 = (state_q == ST_DONE);

endmodule

// File: tb/tb_ref_particle_scheduler.sv
// tb/tb_ref_particle_scheduler.sv - directed bench for ref_particle_scheduler at read latency 1 and 3
module tb_ref_particle_scheduler;

    logic       clk = 1'b0;
    logic       rst, start, stall, pipe_busy;
    logic [6:0] count1, count3;
    logic [6:0] m1 = '0, m3a = '0, m3b = '0, m3c = '0;

    logic       u1_en, u1_rpn, u1_phase, u1_prev, u1_busy, u1_done;
    logic [6:0] u1_addr, u1_pid, u1_ref;
    logic       u3_en, u3_rpn, u3_phase, u3_prev, u3_busy, u3_done;
    logic [6:0] u3_addr, u3_pid, u3_ref;

    int n_vec = 0;
    int n_err = 0;

    int n_en, addr_err, pid_nz, lag_err, n_runs, first_run, run_err, ref_err, prev_err;
    int n_rpn, en0_t, rpn_t, done_t, ref_done, ref_first, ever_phase, done_after, busy_done;

    always #5 clk = ~clk;

    ref_particle_scheduler #(.PARTICLE_ID_WIDTH(7), .RD_LATENCY(1), .DRAIN_CYCLES(16)) u1 (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .pipe_busy(pipe_busy), .rd_num(m1),
        .rd_en(u1_en), .rd_addr(u1_addr), .reading_particle_num(u1_rpn), .particle_id(u1_pid),
        .ref_id(u1_ref), .phase(u1_phase), .prev_phase(u1_prev), .busy(u1_busy), .done(u1_done));

    ref_particle_scheduler #(.PARTICLE_ID_WIDTH(7), .RD_LATENCY(3), .DRAIN_CYCLES(16)) u3 (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .pipe_busy(pipe_busy), .rd_num(m3c),
        .rd_en(u3_en), .rd_addr(u3_addr), .reading_particle_num(u3_rpn), .particle_id(u3_pid),
        .ref_id(u3_ref), .phase(u3_phase), .prev_phase(u3_prev), .busy(u3_busy), .done(u3_done));

    // Home-cell memories: slot 0 holds the count, other slots return their own address.
    always @(posedge clk) begin
        if (u1_en) m1 <= (u1_addr == 7'd0) ? count1 : u1_addr;
        if (u3_en) m3a <= (u3_addr == 7'd0) ? count3 : u3_addr;
        m3b <= m3a;
        m3c <= m3b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_sweep(input string tag, input int which, input int num, input int lat,
                             input int budget, input int pb_len, input int first_run_exp);
        int hist [8];
        int exp_addr, cur_run, pb_left, last_ref, exp_pid;
        logic s_en, s_rpn, s_phase, s_prev, s_done, s_busy, last_phase, pb_used;
        logic [6:0] s_addr, s_pid, s_ref;
        n_en = 0; addr_err = 0; pid_nz = 0; lag_err = 0; n_runs = 0; first_run = -1;
        run_err = 0; ref_err = 0; prev_err = 0; n_rpn = 0; en0_t = -1; rpn_t = -1;
        done_t = -1; ref_done = -1; ref_first = -1; ever_phase = 0; busy_done = -1;
        exp_addr = 0; cur_run = 0; pb_left = 0; last_ref = 0; last_phase = 1'b0; pb_used = 1'b0;
        for (int i = 0; i < 8; i++) hist[i] = 0;
        start = 1'b1;
        for (int t = 0; t < budget && done_t < 0; t++) begin
            cyc(1);
            start = 1'b0;
            if (which == 1) begin
                s_en = u1_en; s_addr = u1_addr; s_pid = u1_pid; s_ref = u1_ref; s_rpn = u1_rpn;
                s_phase = u1_phase; s_prev = u1_prev; s_done = u1_done; s_busy = u1_busy;
            end else begin
                s_en = u3_en; s_addr = u3_addr; s_pid = u3_pid; s_ref = u3_ref; s_rpn = u3_rpn;
                s_phase = u3_phase; s_prev = u3_prev; s_done = u3_done; s_busy = u3_busy;
            end
            exp_pid = (t >= lat) ? hist[(t - lat) % 8] : 0;
            if (int'(s_pid) != exp_pid) lag_err++;
            hist[t % 8] = s_en ? int'(s_addr) : 0;
            if (s_pid != 7'd0) pid_nz++;
            if (s_en) begin
                if (n_en == 0) en0_t = t;
                if (n_en == 1) ref_first = int'(s_ref);
                if (int'(s_addr) != exp_addr) addr_err++;
                n_en++;
                exp_addr = (exp_addr == num) ? 1 : exp_addr + 1;
            end
            if (s_rpn) begin
                n_rpn++;
                rpn_t = t;
            end
            if (s_phase) begin
                if (!last_phase) begin
                    cur_run = 0;
                    if (!pb_used && pb_len > 0) begin
                        pipe_busy = 1'b1;
                        pb_left = pb_len;
                        pb_used = 1'b1;
                    end
                end else if (pb_left > 0) begin
                    pb_left--;
                    if (pb_left == 0) pipe_busy = 1'b0;
                end
                cur_run++;
                ever_phase = 1;
            end
            if (!s_phase && last_phase) begin
                if (n_runs == 0) first_run = cur_run;
                else if (cur_run != 16) run_err++;
                n_runs++;
                if (s_prev !== 1'b1) prev_err++;
                if (!s_done && int'(s_ref) != last_ref + 1) ref_err++;
                if (s_done && int'(s_ref) != last_ref) ref_err++;
            end
            if (s_done) begin
                done_t = t;
                ref_done = int'(s_ref);
                busy_done = int'(s_busy);
            end
            last_phase = s_phase;
            last_ref = int'(s_ref);
        end
        pipe_busy = 1'b0;
        chk({tag, "_done_seen"}, 32'(done_t >= 0), 1);
        cyc(1);
        done_after = (which == 1) ? int'(u1_done) : int'(u3_done);
        chk({tag, "_reads"}, n_en, 1 + num * num);
        chk({tag, "_addr_seq"}, addr_err, 0);
        chk({tag, "_id_matches"}, pid_nz, num * num);
        chk({tag, "_id_lag"}, lag_err, 0);
        chk({tag, "_num_returns"}, n_rpn, 1);
        chk({tag, "_num_lag"}, rpn_t - en0_t, lat);
        chk({tag, "_drain_passes"}, n_runs, num);
        chk({tag, "_ref_at_done"}, ref_done, num);
        chk({tag, "_busy_at_done"}, busy_done, 0);
        chk({tag, "_done_single"}, done_after, 0);
        if (num > 0) begin
            chk({tag, "_ref_first"}, ref_first, 1);
            chk({tag, "_first_drain_len"}, first_run, first_run_exp);
            chk({tag, "_drain_len"}, run_err, 0);
            chk({tag, "_ref_step"}, ref_err, 0);
            chk({tag, "_prev_phase"}, prev_err, 0);
        end else begin
            chk({tag, "_phase_never"}, ever_phase, 0);
            chk({tag, "_done_after_num"}, done_t - rpn_t, 1);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; pipe_busy = 1'b0;
        count1 = 7'd3; count3 = 7'd0;

        #3 rst = 1'b0;
        #1;
        chk("reset_u1", 32'({u1_en, u1_addr, u1_rpn, u1_pid, u1_ref, u1_phase, u1_prev, u1_busy, u1_done}), 0);
        chk("reset_u3", 32'({u3_en, u3_addr, u3_rpn, u3_pid, u3_ref, u3_phase, u3_prev, u3_busy, u3_done}), 0);
        cyc(2);
        rst = 1'b1;
        cyc(1);

        run_sweep("n3", 1, 3, 1, 400, 0, 16);
        cyc(3);

        count1 = 7'd0;
        run_sweep("n0", 1, 0, 1, 50, 0, 0);
        chk("n0_ref_zero", 32'(u1_ref), 0);
        cyc(3);

        count1 = 7'd4;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(3);
        chk("stall_pre", 32'({u1_en, u1_addr, u1_pid}), 32'({1'b1, 7'd2, 7'd1}));
        stall = 1'b1;
        #1;
        chk("stall_c0", 32'({u1_en, u1_addr, u1_pid}), 32'({1'b0, 7'd2, 7'd1}));
        for (int i = 1; i < 5; i++) begin
            cyc(1);
            chk($sformatf("stall_c%0d", i), 32'({u1_en, u1_addr, u1_pid}), 32'({1'b0, 7'd2, 7'd1}));
        end
        cyc(1);
        stall = 1'b0;
        #1;
        chk("stall_release", 32'({u1_en, u1_addr, u1_pid}), 32'({1'b1, 7'd2, 7'd1}));
        cyc(1);
        chk("stall_r1", 32'({u1_en, u1_addr, u1_pid, u1_phase}), 32'({1'b1, 7'd3, 7'd2, 1'b0}));
        cyc(1);
        chk("stall_r2", 32'({u1_en, u1_addr, u1_pid, u1_phase}), 32'({1'b1, 7'd4, 7'd3, 1'b0}));
        cyc(1);
        chk("stall_r3", 32'({u1_en, u1_addr, u1_pid, u1_phase}), 32'({1'b0, 7'd4, 7'd4, 1'b0}));
        cyc(1);
        chk("stall_drain", 32'({u1_phase, u1_pid}), 32'({1'b1, 7'd0}));
        for (int i = 0; i < 500 && !u1_done; i++) cyc(1);
        chk("stall_done", 32'({u1_done, u1_ref}), 32'({1'b1, 7'd4}));
        cyc(3);

        count1 = 7'd2;
        run_sweep("pbusy", 1, 2, 1, 400, 40, 41);
        cyc(3);

        count1 = 7'd0; count3 = 7'd127;
        run_sweep("n127", 3, 127, 3, 20000, 0, 16);
        cyc(3);

        count1 = 7'd3; count3 = 7'd0;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        for (int i = 0; i < 200 && !(u1_ref == 7'd2 && u1_addr == 7'd2 && !u1_phase); i++) cyc(1);
        chk("mid_ref2", 32'({u1_busy, u1_ref, u1_addr, u1_phase}), 32'({1'b1, 7'd2, 7'd2, 1'b0}));
        #2 rst = 1'b0;
        #1;
        chk("mid_reset", 32'({u1_en, u1_addr, u1_rpn, u1_pid, u1_ref, u1_phase, u1_prev, u1_busy, u1_done}), 0);
        cyc(2);
        chk("mid_reset_hold", 32'({u1_en, u1_addr, u1_pid, u1_ref, u1_busy, u1_done}), 0);
        rst = 1'b1;
        cyc(2);
        run_sweep("restart", 1, 3, 1, 400, 0, 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
